alu_issue: RTL and testbench
============================

# alu_issue

Issue stage feeding the ALU: accepts decoded operations from the decode stage, derives the 3-bit ALU control code from ALUOp/funct, selects the second operand, and holds the result in an ID/EX stage register with valid/ready handshakes on both sides. Multiply operations occupy the stage for a fixed settle time before they are presented, covering the ALU's slow combinational multiplier. Sits between the decoder/register file and the ALU, on the ALU's control/operand side.

## Interface
- MUL_LAT, 3, settle cycles a multiply spends in the stage before valid_o (legal 1..15)
- clk_i  in  1  clock, all state on rising edge
- rst_i  in  1  asynchronous, active-high reset
- valid_i  in  1  decode offers an operation
- ready_o  out  1  stage can accept this cycle
- ALUOp_i  in  2  00 load/store, 01 branch, 10 R-type, 11 I-type arithmetic
- funct_i  in  10  {funct7, funct3}
- ALUSrc_i  in  1  1 selects imm_i as second operand
- data1_i  in  32  first operand
- data2_i  in  32  register second operand
- imm_i  in  32  sign-extended immediate
- flush_i  in  1  discard stage contents
- valid_o  out  1  operation presented to the ALU
- ex_ready_i  in  1  EX consumes the presented operation
- ALUCtrl_o  out  3  000 and, 001 or, 010 add, 110 sub, 011 mul
- data1_o  out  32  registered first operand
- data2_o  out  32  registered selected second operand
- busy_o  out  1  multiply settle in progress
- illegal_o  out  1  one-cycle pulse: accepted R-type with unknown funct

## Operation
- States: EMPTY, SETTLE, FULL.
- Accept = valid_i & ready_o & !flush_i. ready_o = !flush_i & (state==EMPTY | (state==FULL & ex_ready_i)).
- Decode: ALUOp 00/11 -> 010; 01 -> 110; 10: 0000000_000 -> 010, 0100000_000 -> 110, 0000000_110 -> 001, 0000000_111 -> 000, 0000001_000 -> 011; any other R-type funct -> 010 with illegal_o pulsed the cycle after accept.
- data2_o = ALUSrc_i ? imm_i : data2_i, captured on accept; data1_o captured on accept.
- Accepted non-mul -> FULL. Accepted mul -> SETTLE with counter loaded to MUL_LAT-1; SETTLE decrements each cycle, moves to FULL when counter is 0 (MUL_LAT=1 gives one SETTLE cycle).
- FULL & ex_ready_i without accept -> EMPTY; with accept -> next state per new op (back-to-back).
- No accept while in SETTLE (ready_o=0).
- flush_i: next state EMPTY from any state, counter cleared, input that cycle dropped, no illegal_o.

## Timing
- Reset values: state EMPTY, valid_o 0, busy_o 0, illegal_o 0, ALUCtrl_o 010, data1_o 0, data2_o 0, counter 0; ready_o therefore 1.
- valid_o = (state==FULL); busy_o = (state==SETTLE).
- Non-mul latency: accept at cycle N -> valid_o at N+1. Mul: valid_o at N+1+MUL_LAT.
- Throughput: one non-mul per cycle when ex_ready_i held 1.
- Outputs stable while valid_o & !ex_ready_i (EX stall).
- Reset asserted mid-SETTLE or mid-FULL: all outputs to reset values immediately, operation lost.

## Configuration
- ALU_MUL_EN defined: mul decode, SETTLE state and counter as above.
- ALU_MUL_EN undefined: 0000001_000 is an unknown funct (010, illegal_o pulse), SETTLE and counter not built, busy_o tied 0, MUL_LAT ignored.

## Test plan
- Reset: rst_i pulse -> valid_o 0, ready_o 1, ALUCtrl_o 010, data outputs 0.
- R-type sub, data1 10, data2 3, ex_ready_i 1 -> next cycle valid_o 1, ALUCtrl_o 110, data2_o 3; stream of and/or/add back-to-back -> one valid_o per cycle, codes 000/001/010.
- I-type, ALUSrc_i 1, imm_i 0xFFFFFFFC -> ALUCtrl_o 010, data2_o 0xFFFFFFFC.
- Mul with MUL_LAT 3 (ALU_MUL_EN) -> busy_o 1 for 3 cycles, ready_o 0, then valid_o 1 with ALUCtrl_o 011; without macro -> ALUCtrl_o 010, illegal_o pulse.
- EX stall: ex_ready_i 0 for 4 cycles with valid_o 1 -> outputs unchanged, ready_o 0; release -> new op accepted same cycle.
- flush_i during SETTLE and together with valid_i -> next cycle EMPTY, valid_o 0, busy_o 0, flushed input not presented.

Source files
------------

// File: rtl/alu_issue_if.sv
// -----------------------------------------------------------------------------
// alu_issue_if
// Bundle of the decode-side and EX-side signals of the ALU issue stage.
//   Decode side : valid_i, ready_o, ALUOp_i, funct_i, ALUSrc_i, data1_i,
//                 data2_i, imm_i, flush_i
//   EX side     : valid_o, ex_ready_i, ALUCtrl_o, data1_o, data2_o,
//                 busy_o, illegal_o
// Modports:
//   slave  - the issue stage itself (alu_issue)
//   master - whoever drives the stage (decode/EX pair, or a testbench)
// -----------------------------------------------------------------------------
interface alu_issue_if;
    logic        valid_i;
    logic        ready_o;
    logic [1:0]  ALUOp_i;
    logic [9:0]  funct_i;
    logic        ALUSrc_i;
    logic [31:0] data1_i;
    logic [31:0] data2_i;
    logic [31:0] imm_i;
    logic        flush_i;
    logic        valid_o;
    logic        ex_ready_i;
    logic [2:0]  ALUCtrl_o;
    logic [31:0] data1_o;
    logic [31:0] data2_o;
    logic        busy_o;
    logic        illegal_o;

    modport slave (
        input  valid_i, ALUOp_i, funct_i, ALUSrc_i, data1_i, data2_i, imm_i,
               flush_i, ex_ready_i,
        output ready_o, valid_o, ALUCtrl_o, data1_o, data2_o, busy_o, illegal_o
    );

    modport master (
        output valid_i, ALUOp_i, funct_i, ALUSrc_i, data1_i, data2_i, imm_i,
               flush_i, ex_ready_i,
        input  ready_o, valid_o, ALUCtrl_o, data1_o, data2_o, busy_o, illegal_o
    );
endinterface

// File: rtl/alu_issue.sv
// -----------------------------------------------------------------------------
// alu_issue
// ID/EX issue stage in front of the ALU. Accepts a decoded operation, derives
// the 3-bit ALU control code from ALUOp/funct, selects the second operand
// (register or immediate) and holds everything in a stage register with
// valid/ready handshakes towards decode and EX. Multiplies are held for
// MUL_LAT settle cycles before being presented, giving the ALU's slow
// combinational multiplier time to resolve.
//
// Optional feature macro: ALU_MUL_EN
//   defined   - multiply decode (funct 0000001_000 -> 011), SETTLE state and
//               settle counter are built.
//   undefined - multiply funct decodes as unknown R-type (add + illegal pulse),
//               no SETTLE state, busy tied low, MUL_LAT has no effect.
//
// Ports:
//   clk_i  - clock, all state on rising edge
//   rst_i  - asynchronous active-high reset
//   bus    - alu_issue_if.slave (decode-side and EX-side handshake/data)
// Parameters:
//   MUL_LAT - settle cycles of a multiply in the stage (1..15)
// -----------------------------------------------------------------------------
module alu_issue #(
    parameter int MUL_LAT = 3
) (
    input  logic        clk_i,
    input  logic        rst_i,
    alu_issue_if.slave  bus
);

    localparam logic [2:0] CTRL_AND = 3'b000;
    localparam logic [2:0] CTRL_OR  = 3'b001;
    localparam logic [2:0] CTRL_ADD = 3'b010;
    localparam logic [2:0] CTRL_SUB = 3'b110;

    // {funct7, funct3}
    localparam logic [9:0] FUNCT_ADD = 10'b0000000_000;
    localparam logic [9:0] FUNCT_SUB = 10'b0100000_000;
    localparam logic [9:0] FUNCT_OR  = 10'b0000000_110;
    localparam logic [9:0] FUNCT_AND = 10'b0000000_111;

    if (MUL_LAT < 1 || MUL_LAT > 15) begin : g_mul_lat_range
        $error("alu_issue: MUL_LAT must be within 1..15");
    end

`ifdef ALU_MUL_EN
    localparam logic [2:0] CTRL_MUL  = 3'b011;
    localparam logic [9:0] FUNCT_MUL = 10'b0000001_000;
    localparam logic [3:0] MUL_LOAD  = 4'(MUL_LAT - 1);

    typedef enum logic [1:0] {
        EMPTY  = 2'd0,
        SETTLE = 2'd1,
        FULL   = 2'd2
    } state_t;
`else
    typedef enum logic [1:0] {
        EMPTY  = 2'd0,
        FULL   = 2'd2
    } state_t;
`endif

    state_t      state_q;
    state_t      state_d;
    state_t      op_state;

    logic [2:0]  dec_ctrl;
    logic        dec_illegal;
`ifdef ALU_MUL_EN
    logic        dec_mul;
    logic [3:0]  cnt_q;
`endif

    logic        ready;
    logic        accept;

    logic [2:0]  ctrl_q;
    logic [31:0] data1_q;
    logic [31:0] data2_q;
    logic        illegal_q;

    // -------------------------------------------------------------------------
    // ALU control decode
    // -------------------------------------------------------------------------
    // NOTE: every signal written here gets a default first so no path leaves
    // it unassigned; otherwise synthesis infers a latch.
    always_comb begin
        dec_ctrl    = CTRL_ADD;
        dec_illegal = 1'b0;
`ifdef ALU_MUL_EN
        dec_mul     = 1'b0;
`endif
        case (bus.ALUOp_i)
            2'b01: dec_ctrl = CTRL_SUB;
            2'b10: begin
                case (bus.funct_i)
                    FUNCT_ADD: dec_ctrl = CTRL_ADD;
                    FUNCT_SUB: dec_ctrl = CTRL_SUB;
                    FUNCT_OR:  dec_ctrl = CTRL_OR;
                    FUNCT_AND: dec_ctrl = CTRL_AND;
`ifdef ALU_MUL_EN
                    FUNCT_MUL: begin
                        dec_ctrl = CTRL_MUL;
                        dec_mul  = 1'b1;
                    end
`endif
                    // Unknown R-type: fall back to add and flag it.
                    default: begin
                        dec_ctrl    = CTRL_ADD;
                        dec_illegal = 1'b1;
                    end
                endcase
            end
            default: dec_ctrl = CTRL_ADD;   // load/store and I-type arithmetic
        endcase
    end

    // -------------------------------------------------------------------------
    // Handshake
    // -------------------------------------------------------------------------
    // A FULL stage can take a new op in the same cycle EX drains the old one.
    assign ready  = !bus.flush_i &&
                    ((state_q == EMPTY) || ((state_q == FULL) && bus.ex_ready_i));
    assign accept = bus.valid_i && ready;

    // -------------------------------------------------------------------------
    // State machine
    // -------------------------------------------------------------------------
`ifdef ALU_MUL_EN
    assign op_state = dec_mul ? SETTLE : FULL;
`else
    assign op_state = FULL;
`endif

    always_comb begin
        state_d = state_q;
        case (state_q)
            EMPTY: begin
                if (accept) state_d = op_state;
            end
`ifdef ALU_MUL_EN
            SETTLE: begin
                if (cnt_q == 4'd0) state_d = FULL;
            end
`endif
            FULL: begin
                if (bus.ex_ready_i) state_d = accept ? op_state : EMPTY;
            end
            default: state_d = EMPTY;
        endcase
        if (bus.flush_i) state_d = EMPTY;
    end

    // NOTE: sequential state is updated with non-blocking assignments so every
    // register samples the pre-edge values regardless of block ordering.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) state_q <= EMPTY;
        else       state_q <= state_d;
    end

`ifdef ALU_MUL_EN
    // Loaded with MUL_LAT-1 on accept so the op spends exactly MUL_LAT cycles
    // in SETTLE (the cycle seeing zero is the last one).
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_q <= 4'd0;
        end else if (bus.flush_i) begin
            cnt_q <= 4'd0;
        end else if (accept && dec_mul) begin
            cnt_q <= MUL_LOAD;
        end else if ((state_q == SETTLE) && (cnt_q != 4'd0)) begin
            cnt_q <= cnt_q - 4'd1;
        end
    end
`endif

    // -------------------------------------------------------------------------
    // Stage register: only loads on accept, so contents hold during EX stall.
    // -------------------------------------------------------------------------
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            ctrl_q  <= CTRL_ADD;
            data1_q <= 32'd0;
            data2_q <= 32'd0;
        end else if (accept) begin
            ctrl_q  <= dec_ctrl;
            data1_q <= bus.data1_i;
            data2_q <= bus.ALUSrc_i ? bus.imm_i : bus.data2_i;
        end
    end

    // accept already excludes flush, so a flushed op never raises illegal.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) illegal_q <= 1'b0;
        else       illegal_q <= accept && dec_illegal;
    end

    // -------------------------------------------------------------------------
    // Outputs
    // -------------------------------------------------------------------------
    assign bus.ready_o   = ready;
    assign bus.valid_o   = (state_q == FULL);
    assign bus.ALUCtrl_o = ctrl_q;
    assign bus.data1_o   = data1_q;
    assign bus.data2_o   = data2_q;
    assign bus.illegal_o = illegal_q;
`ifdef ALU_MUL_EN
    assign bus.busy_o    = (state_q == SETTLE);
`else
    assign bus.busy_o    = 1'b0;
`endif

endmodule

// File: tb/tb_alu_issue.sv
// -----------------------------------------------------------------------------
// tb_alu_issue
// Self-checking bench for alu_issue. A table of decoded operations is issued
// back-to-back; expected results go to a scoreboard queue when an op is
// accepted and are compared when the stage presents it to EX. Multiply
// settle, EX stall, flush and mid-operation reset are hand-written sequences.
// Honours ALU_MUL_EN the same way the design does.
// -----------------------------------------------------------------------------
module tb_alu_issue;

    localparam int MUL_LAT = 3;

    typedef struct {
        logic [1:0]  aluop;
        logic [9:0]  funct;
        logic        alusrc;
        logic [31:0] d1;
        logic [31:0] d2;
        logic [31:0] imm;
        logic [2:0]  exp_ctrl;
        logic [31:0] exp_d2;
        logic        exp_ill;
    } vec_t;

    typedef struct {
        logic [2:0]  ctrl;
        logic [31:0] d1;
        logic [31:0] d2;
    } res_t;

    typedef struct {
        int   cyc;
        logic ill;
    } ill_t;

    logic clk;
    logic rst;

    alu_issue_if bus ();

    alu_issue #(.MUL_LAT(MUL_LAT)) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus.slave)
    );

    res_t sb[$];
    ill_t ill_q[$];
    int   cyc;
    int   n_total;
    int   n_pass;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        n_total++;
        if (act !== exp)
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
        else
            n_pass++;
    endtask

    // Result monitor: every op handed to EX must match the scoreboard head.
    always @(negedge clk) begin
        if (!rst && bus.valid_o && bus.ex_ready_i) begin
            if (sb.size() == 0) begin
                check("unexpected_valid", bus.valid_o, 1'b0);
            end else begin
                check("res_ctrl", bus.ALUCtrl_o, sb[0].ctrl);
                check("res_data1", bus.data1_o, sb[0].d1);
                check("res_data2", bus.data2_o, sb[0].d2);
                void'(sb.pop_front());
            end
        end
    end

    // illegal_o must pulse exactly the cycle after an accept of an unknown
    // R-type op, and never otherwise.
    always @(negedge clk) begin
        if (!rst) begin
            if (ill_q.size() > 0 && cyc == ill_q[0].cyc + 1) begin
                check("illegal_pulse", bus.illegal_o, ill_q[0].ill);
                void'(ill_q.pop_front());
            end else if (bus.illegal_o) begin
                check("illegal_spurious", bus.illegal_o, 1'b0);
            end
        end
    end

    // Drive one op, wait (bounded) for ready_o, record expectations, and
    // leave the bus idle #1 after the accepting edge.
    task automatic issue(input vec_t v, output int waits);
        res_t r;
        ill_t e;
        bus.ALUOp_i  = v.aluop;
        bus.funct_i  = v.funct;
        bus.ALUSrc_i = v.alusrc;
        bus.data1_i  = v.d1;
        bus.data2_i  = v.d2;
        bus.imm_i    = v.imm;
        bus.valid_i  = 1'b1;
        waits = 0;
        forever begin
            @(negedge clk);
            if (bus.ready_o) break;
            waits++;
            if (waits > 50) begin
                check("issue_timeout", 32'(waits), 32'd0);
                bus.valid_i = 1'b0;
                return;
            end
        end
        r.ctrl = v.exp_ctrl;
        r.d1   = v.d1;
        r.d2   = v.exp_d2;
        sb.push_back(r);
        e.cyc = cyc;
        e.ill = v.exp_ill;
        ill_q.push_back(e);
        @(posedge clk);
        #1;
        bus.valid_i = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    vec_t vecs[9];
    vec_t v;
    int   w;

    initial begin
        n_total = 0;
        n_pass  = 0;
        cyc     = 0;

        //             aluop  funct           src  d1     d2     imm            ctrl    exp_d2         ill
        vecs[0] = '{2'b10, 10'b0100000_000, 1'b0, 32'd10, 32'd3,  32'd0,        3'b110, 32'd3,         1'b0};
        vecs[1] = '{2'b10, 10'b0000000_111, 1'b0, 32'hF0, 32'h3C, 32'd0,        3'b000, 32'h3C,        1'b0};
        vecs[2] = '{2'b10, 10'b0000000_110, 1'b0, 32'h11, 32'h22, 32'd0,        3'b001, 32'h22,        1'b0};
        vecs[3] = '{2'b10, 10'b0000000_000, 1'b0, 32'd5,  32'd9,  32'd0,        3'b010, 32'd9,         1'b0};
        vecs[4] = '{2'b11, 10'b0000000_000, 1'b1, 32'd20, 32'd5,  32'hFFFFFFFC, 3'b010, 32'hFFFFFFFC,  1'b0};
        vecs[5] = '{2'b00, 10'b0101010_101, 1'b1, 32'h1000, 32'd1, 32'd8,       3'b010, 32'd8,         1'b0};
        vecs[6] = '{2'b01, 10'b0000000_000, 1'b0, 32'd7,  32'd7,  32'd64,       3'b110, 32'd7,         1'b0};
        vecs[7] = '{2'b10, 10'b0000000_001, 1'b0, 32'd1,  32'd2,  32'd0,        3'b010, 32'd2,         1'b1};
        vecs[8] = '{2'b01, 10'b1111111_111, 1'b0, 32'd3,  32'd4,  32'd0,        3'b110, 32'd4,         1'b0};

        // ---------------- reset state ----------------
        rst            = 1'b1;
        bus.valid_i    = 1'b0;
        bus.ALUOp_i    = 2'b00;
        bus.funct_i    = 10'd0;
        bus.ALUSrc_i   = 1'b0;
        bus.data1_i    = 32'd0;
        bus.data2_i    = 32'd0;
        bus.imm_i      = 32'd0;
        bus.flush_i    = 1'b0;
        bus.ex_ready_i = 1'b1;
        @(negedge clk);
        check("rst_valid", bus.valid_o, 1'b0);
        check("rst_ready", bus.ready_o, 1'b1);
        check("rst_ctrl", bus.ALUCtrl_o, 3'b010);
        check("rst_data1", bus.data1_o, 32'd0);
        check("rst_data2", bus.data2_o, 32'd0);
        check("rst_busy", bus.busy_o, 1'b0);
        check("rst_illegal", bus.illegal_o, 1'b0);
        @(posedge clk);
        #1 rst = 1'b0;

        // ---------------- table stream, back-to-back ----------------
        for (int i = 0; i < 9; i++) begin
            issue(vecs[i], w);
            check($sformatf("stream_wait_%0d", i), 32'(w), 32'd0);
        end
        repeat (3) @(negedge clk);
        check("stream_drained", 32'(sb.size()), 32'd0);

        // ---------------- multiply ----------------
        v = '{2'b10, 10'b0000001_000, 1'b0, 32'd6, 32'd7, 32'd0,
`ifdef ALU_MUL_EN
              3'b011, 32'd7, 1'b0};
`else
              3'b010, 32'd7, 1'b1};
`endif
        @(posedge clk);
        #1;
        issue(v, w);
        check("mul_wait", 32'(w), 32'd0);
`ifdef ALU_MUL_EN
        for (int k = 0; k < MUL_LAT; k++) begin
            if (k > 0) @(negedge clk);
            check($sformatf("mul_busy_%0d", k), bus.busy_o, 1'b1);
            check($sformatf("mul_ready_%0d", k), bus.ready_o, 1'b0);
            check($sformatf("mul_valid_%0d", k), bus.valid_o, 1'b0);
        end
        @(negedge clk);
`endif
        check("mul_valid", bus.valid_o, 1'b1);
        check("mul_busy_done", bus.busy_o, 1'b0);
        @(posedge clk);
        #1;

        // ---------------- EX stall ----------------
        bus.ex_ready_i = 1'b0;
        v = '{2'b10, 10'b0100000_000, 1'b0, 32'd100, 32'd40, 32'd0, 3'b110, 32'd40, 1'b0};
        issue(v, w);
        // Next op waits at the input while EX is stalled.
        bus.ALUOp_i  = 2'b10;
        bus.funct_i  = 10'b0000000_110;
        bus.ALUSrc_i = 1'b0;
        bus.data1_i  = 32'hAAAA;
        bus.data2_i  = 32'h5555;
        bus.valid_i  = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            check("stall_valid", bus.valid_o, 1'b1);
            check("stall_ready", bus.ready_o, 1'b0);
            check("stall_ctrl", bus.ALUCtrl_o, 3'b110);
            check("stall_data1", bus.data1_o, 32'd100);
            check("stall_data2", bus.data2_o, 32'd40);
        end
        @(posedge clk);
        #1 bus.ex_ready_i = 1'b1;
        v = '{2'b10, 10'b0000000_110, 1'b0, 32'hAAAA, 32'h5555, 32'd0, 3'b001, 32'h5555, 1'b0};
        issue(v, w);
        check("stall_release_wait", 32'(w), 32'd0);
        repeat (2) @(negedge clk);
        check("stall_drained", 32'(sb.size()), 32'd0);

        // ---------------- flush in FULL together with valid_i ----------------
        @(posedge clk);
        #1 bus.ex_ready_i = 1'b0;
        v = '{2'b10, 10'b0000000_000, 1'b0, 32'd1, 32'd1, 32'd0, 3'b010, 32'd1, 1'b0};
        issue(v, w);
        bus.flush_i = 1'b1;
        bus.valid_i = 1'b1;
        bus.ALUOp_i = 2'b10;
        bus.funct_i = 10'b0000000_001;   // would pulse illegal if accepted
        @(negedge clk);
        check("flush_ready", bus.ready_o, 1'b0);
        @(posedge clk);
        #1;
        bus.flush_i = 1'b0;
        bus.valid_i = 1'b0;
        void'(sb.pop_back());
        @(negedge clk);
        check("flush_valid", bus.valid_o, 1'b0);
        check("flush_ready_after", bus.ready_o, 1'b1);
        check("flush_busy", bus.busy_o, 1'b0);
        bus.ex_ready_i = 1'b1;
        repeat (3) @(negedge clk);

`ifdef ALU_MUL_EN
        // ---------------- flush during SETTLE ----------------
        @(posedge clk);
        #1;
        v = '{2'b10, 10'b0000001_000, 1'b0, 32'd2, 32'd3, 32'd0, 3'b011, 32'd3, 1'b0};
        issue(v, w);
        bus.flush_i = 1'b1;
        bus.valid_i = 1'b1;
        @(negedge clk);
        check("sflush_busy_before", bus.busy_o, 1'b1);
        @(posedge clk);
        #1;
        bus.flush_i = 1'b0;
        bus.valid_i = 1'b0;
        void'(sb.pop_back());
        @(negedge clk);
        check("sflush_busy", bus.busy_o, 1'b0);
        check("sflush_valid", bus.valid_o, 1'b0);
        repeat (MUL_LAT + 2) @(negedge clk);

        // ---------------- reset mid-SETTLE ----------------
        @(posedge clk);
        #1;
        issue(v, w);
        #2 rst = 1'b1;
        #1;
        check("rst_settle_busy", bus.busy_o, 1'b0);
        check("rst_settle_ready", bus.ready_o, 1'b1);
        sb.delete();
        ill_q.delete();
        @(posedge clk);
        #1 rst = 1'b0;
`endif

        // ---------------- reset mid-FULL ----------------
        @(posedge clk);
        #1 bus.ex_ready_i = 1'b0;
        v = '{2'b10, 10'b0000000_111, 1'b0, 32'h77, 32'h88, 32'd0, 3'b000, 32'h88, 1'b0};
        issue(v, w);
        #2 rst = 1'b1;
        #1;
        check("rst_full_valid", bus.valid_o, 1'b0);
        check("rst_full_ctrl", bus.ALUCtrl_o, 3'b010);
        check("rst_full_data1", bus.data1_o, 32'd0);
        check("rst_full_data2", bus.data2_o, 32'd0);
        sb.delete();
        ill_q.delete();
        @(posedge clk);
        #1;
        rst = 1'b0;
        bus.ex_ready_i = 1'b1;

        repeat (4) @(negedge clk);
        check("final_sb_empty", 32'(sb.size()), 32'd0);
        check("final_valid_idle", bus.valid_o, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
